sync_fifo_v2: RTL

Parametrised synchronous FIFO. It succeeds the fixed 8x16 FIFO and generalises width and depth. It adds a fill count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. It is used as the standard single-clock buffer between streaming stages, and its optional first-word-fall-through (FWFT) mode is selected at compile time.

---
 rtl/sync_fifo_v2.sv | 112 +++++++++++
 1 files changed

// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO with fill count, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_v2 #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_TH = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_ovf;
  logic             r_udf;

  logic [AW:0]      w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_wr_rej;
  logic             w_rd_rej;

  // Extra pointer MSB tells a full ring from an empty one
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0])
                && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_wr_acc = wr_en && !w_full  && !flush;
  assign w_rd_acc = rd_en && !w_empty && !flush;
  assign w_wr_rej = wr_en && w_full   && !flush;
  assign w_rd_rej = rd_en && w_empty  && !flush;

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= AF_TH);
  assign almost_empty = (w_count <= AE_TH);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (flush) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr_rej)
        r_ovf <= 1'b1;
      if (w_rd_rej)
        r_udf <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = r_mem[r_rd_ptr[AW-1:0]];
`else
  logic [WIDTH-1:0] r_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_dout <= '0;
    else if (w_rd_acc)
      r_dout <= r_mem[r_rd_ptr[AW-1:0]];
  end

  assign dout = r_dout;
`endif

endmodule
